lsu_bank_arbiter: RTL and testbench



---
 rtl/lsu_bank_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_lsu_bank_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bank_arbiter.sv
// ---------------------------------------------------------------------------
// lsu_bank_arbiter
//
// Bank arbiter in front of the 8x8 LSU address crossbar. Eight LSU ports
// present {bank_sel[2:0], addr} requests. Per bank at most one pending port is
// granted each cycle. Every port, granted or not, is mapped onto a distinct
// bank, so the crossbar always receives a collision-free permutation.
// bank_en marks which banks carry real (granted) accesses. bank_src records
// which port drives each bank, for read-data return routing.
//
// Configuration macro:
//   LSU_ARB_RR_EN  defined   -> per-bank round-robin pointers.
//                  undefined -> fixed priority, highest port index wins.
//
// Widths come from `A_W (address) and `A_bus (= `A_W + 3). Defaults are
// provided when the surrounding build does not define them.
//
// Ports:
//   clk              in   clock, all state on the rising edge
//   rst              in   asynchronous, active-high reset
//   req_valid[7:0]   in   per-port request valid
//   req_bus          in   8 packed requests, slice n = {bank_sel, addr}
//   req_ready[7:0]   out  combinational grant, low while rst is high
//   LSU_addr_bus_n   out  registered {assigned bank, addr} for port n
//   bank_en[7:0]     out  registered, bank b carries a granted access
//   bank_src[23:0]   out  registered, 3-bit field b = port assigned to bank b
// ---------------------------------------------------------------------------
`ifndef A_W
`define A_W 16
`endif
`ifndef A_bus
`define A_bus (`A_W+3)
`endif

module lsu_bank_arbiter (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              req_valid,
    input  logic [8*`A_bus-1:0]     req_bus,
    output logic [7:0]              req_ready,
    output logic [`A_bus-1:0]       LSU_addr_bus_7,
    output logic [`A_bus-1:0]       LSU_addr_bus_6,
    output logic [`A_bus-1:0]       LSU_addr_bus_5,
    output logic [`A_bus-1:0]       LSU_addr_bus_4,
    output logic [`A_bus-1:0]       LSU_addr_bus_3,
    output logic [`A_bus-1:0]       LSU_addr_bus_2,
    output logic [`A_bus-1:0]       LSU_addr_bus_1,
    output logic [`A_bus-1:0]       LSU_addr_bus_0,
    output logic [7:0]              bank_en,
    output logic [23:0]             bank_src
);

    localparam int unsigned AW = `A_W;
    localparam int unsigned BW = `A_bus;

    // Unpacked request fields
    logic [2:0]    sel  [8];
    logic [AW-1:0] addr [8];

    always_comb begin
        for (int unsigned n = 0; n < 8; n++) begin
            sel[n]  = req_bus[n*BW+AW +: 3];
            addr[n] = req_bus[n*BW +: AW];
        end
    end

    // -----------------------------------------------------------------------
    // Per-bank arbitration
    // -----------------------------------------------------------------------
    logic [7:0] has_win;
    logic [2:0] win   [8];
    logic [7:0] grant;

`ifdef LSU_ARB_RR_EN
    logic [2:0] ptr [8];
    logic [2:0] idx;

    // First candidate at or above the bank's pointer, wrapping at 8.
    always_comb begin
        has_win = '0;
        idx     = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            win[b] = '0;
            for (int unsigned k = 0; k < 8; k++) begin
                idx = ptr[b] + 3'(k);
                if (!has_win[b] && req_valid[idx] && (sel[idx] == 3'(b))) begin
                    has_win[b] = 1'b1;
                    win[b]     = idx;
                end
            end
        end
        if (rst) begin
            has_win = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned b = 0; b < 8; b++) begin
                ptr[b] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (has_win[b]) begin
                    ptr[b] <= win[b] + 3'd1;
                end
            end
        end
    end
`else
    // Ascending scan, so the highest-index candidate overwrites lower ones.
    always_comb begin
        has_win = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            win[b] = '0;
            for (int unsigned n = 0; n < 8; n++) begin
                if (req_valid[n] && (sel[n] == 3'(b))) begin
                    has_win[b] = 1'b1;
                    win[b]     = 3'(n);
                end
            end
        end
        if (rst) begin
            has_win = '0;
        end
    end
`endif

    always_comb begin
        grant = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            if (has_win[b]) begin
                grant[win[b]] = 1'b1;
            end
        end
    end

    assign req_ready = grant;

    // -----------------------------------------------------------------------
    // Permutation fill: winners keep their bank; every other port, in
    // ascending order, claims the lowest still-free bank. The number of
    // non-winning ports always equals the number of free banks, so each
    // port finds exactly one bank.
    // -----------------------------------------------------------------------
    logic [7:0] free;
    logic       found;
    logic [2:0] asg [8];
    logic [2:0] src [8];

    always_comb begin
        free  = ~has_win;
        found = 1'b0;
        for (int unsigned n = 0; n < 8; n++) begin
            asg[n] = '0;
            found  = 1'b0;
            if (grant[n]) begin
                asg[n] = sel[n];
            end else begin
                for (int unsigned b = 0; b < 8; b++) begin
                    if (!found && free[b]) begin
                        asg[n]  = 3'(b);
                        free[b] = 1'b0;
                        found   = 1'b1;
                    end
                end
            end
        end
        for (int unsigned b = 0; b < 8; b++) begin
            src[b] = '0;
        end
        for (int unsigned n = 0; n < 8; n++) begin
            src[asg[n]] = 3'(n);
        end
    end

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    logic [BW-1:0] bus_q [8];
    logic [7:0]    en_q;
    logic [2:0]    src_q [8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned n = 0; n < 8; n++) begin
                bus_q[n] <= {3'(n), {AW{1'b0}}};
                src_q[n] <= 3'(n);
            end
            en_q <= '0;
        end else begin
            for (int unsigned n = 0; n < 8; n++) begin
                bus_q[n] <= {asg[n], (req_valid[n] ? addr[n] : {AW{1'b0}})};
                src_q[n] <= src[n];
            end
            en_q <= has_win;
        end
    end

    assign LSU_addr_bus_0 = bus_q[0];
    assign LSU_addr_bus_1 = bus_q[1];
    assign LSU_addr_bus_2 = bus_q[2];
    assign LSU_addr_bus_3 = bus_q[3];
    assign LSU_addr_bus_4 = bus_q[4];
    assign LSU_addr_bus_5 = bus_q[5];
    assign LSU_addr_bus_6 = bus_q[6];
    assign LSU_addr_bus_7 = bus_q[7];
    assign bank_en        = en_q;
    assign bank_src       = {src_q[7], src_q[6], src_q[5], src_q[4],
                             src_q[3], src_q[2], src_q[1], src_q[0]};

endmodule

// File: tb/tb_lsu_bank_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lsu_bank_arbiter
//
// Scoreboard bench for lsu_bank_arbiter. The stimulus process drives requests
// and pushes the reference model's expected grant / registered outputs into a
// queue. A monitor pops each entry and checks req_ready mid-cycle and the
// registered outputs just after the following rising edge.
// ---------------------------------------------------------------------------
`ifndef A_W
`define A_W 16
`endif
`ifndef A_bus
`define A_bus (`A_W+3)
`endif

module tb_lsu_bank_arbiter;

    localparam int AW = `A_W;
    localparam int BW = `A_bus;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        req_valid;
    logic [8*BW-1:0]   req_bus;
    logic [7:0]        req_ready;
    logic [BW-1:0]     obus [8];
    logic [7:0]        bank_en;
    logic [23:0]       bank_src;

    lsu_bank_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_bus        (req_bus),
        .req_ready      (req_ready),
        .LSU_addr_bus_7 (obus[7]),
        .LSU_addr_bus_6 (obus[6]),
        .LSU_addr_bus_5 (obus[5]),
        .LSU_addr_bus_4 (obus[4]),
        .LSU_addr_bus_3 (obus[3]),
        .LSU_addr_bus_2 (obus[2]),
        .LSU_addr_bus_1 (obus[1]),
        .LSU_addr_bus_0 (obus[0]),
        .bank_en        (bank_en),
        .bank_src       (bank_src)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]      ready;
        logic [8*BW-1:0] bus;
        logic [7:0]      en;
        logic [23:0]     src;
    } exp_t;

    exp_t q [$];
    int   nvec = 0;
    int   nerr = 0;
    bit   mon_busy = 1'b0;

    // Stimulus state and reference-model state
    logic [7:0] v;
    int         bk [8];
    int         ad [8];
    int         ptr [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < 8; p++) begin
            req_valid[p]           = v[p];
            req_bus[p*BW +: BW]    = {3'(bk[p]), AW'(ad[p])};
        end
    endtask

    // Reference model: pick one winner per bank, then hand the free banks in
    // ascending order to the remaining ports in ascending order.
    task automatic predict(output exp_t e);
        int winner [8];
        int bank_of [8];
        int freeq [$];
        e = '0;
        for (int b = 0; b < 8; b++) winner[b] = -1;
        for (int p = 0; p < 8; p++) bank_of[p] = -1;
        for (int b = 0; b < 8; b++) begin
`ifdef LSU_ARB_RR_EN
            for (int off = 0; off < 8; off++) begin
                int c;
                c = (ptr[b] + off) % 8;
                if (winner[b] < 0 && v[c] && bk[c] == b) winner[b] = c;
            end
`else
            for (int c = 7; c >= 0; c--) begin
                if (winner[b] < 0 && v[c] && bk[c] == b) winner[b] = c;
            end
`endif
        end
        for (int b = 0; b < 8; b++) begin
            if (winner[b] >= 0) begin
                bank_of[winner[b]] = b;
                e.ready[winner[b]] = 1'b1;
                e.en[b]            = 1'b1;
                ptr[b]             = (winner[b] + 1) % 8;
            end else begin
                freeq.push_back(b);
            end
        end
        for (int p = 0; p < 8; p++) begin
            if (bank_of[p] < 0) bank_of[p] = freeq.pop_front();
        end
        for (int p = 0; p < 8; p++) begin
            e.bus[p*BW +: BW]     = {3'(bank_of[p]), (v[p] ? AW'(ad[p]) : AW'(0))};
            e.src[3*bank_of[p] +: 3] = 3'(p);
        end
    endtask

    task automatic issue(output exp_t e);
        @(posedge clk);
        #1;
        drive();
        predict(e);
        q.push_back(e);
    endtask

    // Keep issuing; granted ports drop out, losers stay valid and stable.
    task automatic drain_reqs();
        exp_t e;
        for (int i = 0; i < 16 && v != 0; i++) begin
            issue(e);
            v = v & ~e.ready;
        end
        nvec++;
        if (v != 0) begin
            nerr++;
            $display("FAIL drain_timeout: pending %h, expected 00", v);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || mon_busy) && n < 10) begin
            @(posedge clk);
            #3;
            n++;
        end
        nvec++;
        if (q.size() != 0 || mon_busy) begin
            nerr++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
    endtask

    task automatic check_reset_state();
        logic [23:0] s;
        s = '0;
        for (int b = 0; b < 8; b++) s[3*b +: 3] = 3'(b);
        chk("rst_req_ready", req_ready, 8'h00);
        chk("rst_bank_en", bank_en, 8'h00);
        chk("rst_bank_src", bank_src, s);
        for (int n = 0; n < 8; n++)
            chk($sformatf("rst_bus%0d", n), obus[n], {3'(n), AW'(0)});
    endtask

    // Monitor
    initial begin
        exp_t me;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                mon_busy = 1'b1;
                me = q.pop_front();
                chk("req_ready", req_ready, me.ready);
                @(posedge clk);
                #2;
                chk("bank_en", bank_en, me.en);
                chk("bank_src", bank_src, me.src);
                for (int n = 0; n < 8; n++)
                    chk($sformatf("bus%0d", n), obus[n], me.bus[n*BW +: BW]);
                mon_busy = 1'b0;
            end
        end
    end

    // Stimulus
    initial begin
        exp_t e;
        rst = 1'b1;
        v   = 8'hFF;
        for (int p = 0; p < 8; p++) begin
            bk[p]  = p;
            ad[p]  = 0;
            ptr[p] = 0;
        end
        drive();
        #2;
        check_reset_state();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        v   = '0;

        // Permutation fill (pointers at 0)
        v = 8'b0101_0010;
        bk[1] = 0; ad[1] = 'h11;
        bk[6] = 0; ad[6] = 'h66;
        bk[4] = 5; ad[4] = 'h44;
        drain_reqs();

        // Conflict-free: port n -> bank 7-n
        v = 8'hFF;
        for (int p = 0; p < 8; p++) begin
            bk[p] = 7 - p;
            ad[p] = 'h10 + p;
        end
        drain_reqs();

        // Full conflict on bank 2
        v = 8'b0010_1001;
        for (int p = 0; p < 8; p++) begin
            bk[p] = 2;
            ad[p] = 'h200 + p;
        end
        drain_reqs();

        // Back-to-back from port 2 to bank 3
        v = 8'b0000_0100; bk[2] = 3; ad[2] = 'h40;
        issue(e);
        v = 8'b0000_0100; ad[2] = 'h44;
        issue(e);
        v = '0;
        issue(e);

        // Fairness: ports 0 and 7 both keep targeting bank 4
        bk[0] = 4; bk[7] = 4; ad[0] = 'h400; ad[7] = 'h407;
        for (int i = 0; i < 6; i++) begin
            v = 8'h81;
            issue(e);
        end
        v = '0;
        issue(e);

        // Randomized traffic with stable pending requests
        for (int i = 0; i < 300; i++) begin
            issue(e);
            for (int p = 0; p < 8; p++) begin
                if (!(v[p] && !e.ready[p])) begin
                    v[p]  = ($urandom_range(0, 9) < 6);
                    bk[p] = $urandom_range(0, 7);
                    ad[p] = $urandom;
                end
            end
        end

        // Reset in the middle of traffic
        wait_idle();
        drive();
        rst = 1'b1;
        #1;
        check_reset_state();
        @(posedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;
        for (int b = 0; b < 8; b++) ptr[b] = 0;
        if (v == 0) v = 8'h0F;
        drain_reqs();

        // Tail of random traffic after reset
        for (int i = 0; i < 100; i++) begin
            issue(e);
            for (int p = 0; p < 8; p++) begin
                if (!(v[p] && !e.ready[p])) begin
                    v[p]  = ($urandom_range(0, 9) < 7);
                    bk[p] = $urandom_range(0, 7);
                    ad[p] = $urandom;
                end
            end
        end

        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
        $fatal(1);
    end

endmodule
